// File: rtl/aes_trace_seq_if.sv
// Bus between the trace sequencer and the AES core it drives.
// master = sequencer side, slave = core side.
interface aes_trace_seq_if;
  logic         aes_rst;
  logic [127:0] aes_din;
  logic [127:0] aes_key;
  logic [127:0] aes_dout;
  logic         aes_done;

  modport master (
    output aes_rst,
    output aes_din,
    output aes_key,
    input  aes_dout,
    input  aes_done
  );

  modport slave (
    input  aes_rst,
    input  aes_din,
    input  aes_key,
    output aes_dout,
    output aes_done
  );
endinterface

// File: rtl/aes_trace_seq.sv
// Batch sequencer for side-channel trace capture: feeds an AES core,
// raises trig while it runs and captures each ciphertext.
module aes_trace_seq #(
  parameter int TIMEOUT = 255,
  parameter int GAP_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  num_enc,
  input  logic         chain,
  input  logic [127:0] key_in,
  input  logic [127:0] pt_seed,
  aes_trace_seq_if.master core,
  output logic         trig,
  output logic [127:0] ct_out,
  output logic         ct_valid,
  output logic         busy,
  output logic         done_all,
  output logic         timeout,
  output logic [15:0]  enc_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, CAPT, GAP, FIN, ERR
  } state_t;

  state_t state, nxt;

  logic [127:0] key_r;
  logic [127:0] pt_r;
  logic         chain_r;
  logic [15:0]  num_r;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic          aes_rst_c;

  logic tmo_hit;
  logic last_enc;
  logic gap_end;

  assign tmo_hit  = (timer == TW'(TIMEOUT - 1));
  assign last_enc = ({1'b0, enc_cnt} + 17'd1)
                    == {1'b0, num_r};
  assign gap_end  = (gap_cnt == GW'(GAP_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // aes_done is tested first so it wins over a coincident timeout
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start)
              nxt = (num_enc == 16'd0) ? FIN : LOAD;
      LOAD: nxt = RUN;
      RUN:  if (core.aes_done) nxt = CAPT;
            else if (tmo_hit)  nxt = ERR;
      CAPT: nxt = last_enc ? FIN : GAP;
      GAP:  if (gap_end) nxt = LOAD;
      FIN:  nxt = IDLE;
      ERR:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    aes_rst_c = 1'b0;
    trig      = 1'b0;
    ct_valid  = 1'b0;
    done_all  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        aes_rst_c = 1'b1;
        busy      = 1'b0;
      end
      LOAD: aes_rst_c = 1'b1;
      RUN:  trig      = 1'b1;
      CAPT: ct_valid  = 1'b1;
      GAP:  busy      = 1'b1;
      FIN:  done_all  = 1'b1;
      ERR:  aes_rst_c = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  assign core.aes_rst = aes_rst_c;
  assign core.aes_din = pt_r;
  assign core.aes_key = key_r;

  // ct_out is taken with aes_done so it is valid alongside ct_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r   <= '0;
      pt_r    <= '0;
      chain_r <= 1'b0;
      num_r   <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      enc_cnt <= '0;
      ct_out  <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          key_r   <= key_in;
          pt_r    <= pt_seed;
          chain_r <= chain;
          num_r   <= num_enc;
          enc_cnt <= '0;
          timeout <= 1'b0;
        end
        LOAD: timer <= '0;
        RUN: begin
          timer <= timer + 1'b1;
          if (core.aes_done)
            ct_out <= core.aes_dout;
          else if (tmo_hit)
            timeout <= 1'b1;
        end
        CAPT: begin
          enc_cnt <= enc_cnt + 16'd1;
          gap_cnt <= '0;
          pt_r    <= chain_r ? core.aes_dout
                             : pt_r + 128'd1;
        end
        GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_trace_seq.sv
// Bench for aes_trace_seq: software AES stands in for the core,
// a scoreboard queue holds the ciphertexts expected on ct_valid.
module tb_aes_trace_seq;

  localparam int TMO = 16;
  localparam int GAP = 4;
  localparam int LAT = 3;

  localparam logic [127:0] K =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  num_enc;
  logic         chain;
  logic [127:0] key_in;
  logic [127:0] pt_seed;
  logic         trig;
  logic [127:0] ct_out;
  logic         ct_valid;
  logic         busy;
  logic         done_all;
  logic         timeout;
  logic [15:0]  enc_cnt;

  aes_trace_seq_if bus ();

  aes_trace_seq #(
    .TIMEOUT(TMO),
    .GAP_CYC(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_enc(num_enc),
    .chain(chain),
    .key_in(key_in),
    .pt_seed(pt_seed),
    .core(bus.master),
    .trig(trig),
    .ct_out(ct_out),
    .ct_valid(ct_valid),
    .busy(busy),
    .done_all(done_all),
    .timeout(timeout),
    .enc_cnt(enc_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // ---------------- AES-128 software model
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b, r;
      b = 8'(v);
      r = (b == 8'h00) ? 8'h00 : 8'h01;
      if (b != 8'h00)
        for (int k = 0; k < 254; k++) r = gmul(r, b);
      sbox[v] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
              ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
              ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(
      input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]],
               sbox[tmp[15:8]], sbox[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1];
          a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int i = 0; i < 16; i++)
        s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- AES core stub, fixed latency
  logic stall;
  int   lat;

  always @(posedge clk) begin
    if (bus.aes_rst === 1'b1) begin
      lat <= 0;
      bus.aes_done <= 1'b0;
    end else if (!stall && bus.aes_done !== 1'b1) begin
      if (lat == LAT - 1) begin
        bus.aes_done <= 1'b1;
        bus.aes_dout <= aes_enc(bus.aes_din, bus.aes_key);
      end else begin
        lat <= lat + 1;
      end
    end
  end

  // ---------------- monitor and scoreboard
  logic [127:0] sb [$];
  logic [127:0] loads [$];
  int gaps [$];
  int cyc = 0;
  int nct = 0;
  int ndone = 0;
  int ntrig = 0;
  int nrun = 0;
  int last_ct = -10;
  int last_done = -10;
  int fell = -1;
  logic ptrig = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    check("valid_and_done", 128'(ct_valid & done_all), 128'(0));
    if (ct_valid === 1'b1) begin
      nct <= nct + 1;
      last_ct <= cyc;
      if (sb.size() > 0)
        check("ct_out", ct_out, sb.pop_front());
      else
        check("ct_valid_unexpected", 128'(ct_valid), 128'(0));
    end
    if (done_all === 1'b1) begin
      ndone <= ndone + 1;
      last_done <= cyc;
    end
    if (trig === 1'b1) nrun <= nrun + 1;
    if (trig === 1'b1 && !ptrig) begin
      ntrig <= ntrig + 1;
      if (fell >= 0) gaps.push_back(cyc - fell);
    end
    if (trig !== 1'b1 && ptrig) fell <= cyc;
    ptrig <= (trig === 1'b1);
    if (bus.aes_rst === 1'b1 && busy === 1'b1)
      loads.push_back(bus.aes_din);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_all !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check(tag, 128'(done_all), 128'(1));
  endtask

  task automatic go(input logic [15:0] n,
                    input logic c,
                    input logic [127:0] pt);
    key_in = K; pt_seed = pt; num_enc = n; chain = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed sequence
  initial begin
    logic [127:0] ct2, ct3;
    int c0, d0, t0, g0, l0, r0, n;
    build_sbox();
    rst = 1'b1; start = 1'b0; chain = 1'b0;
    num_enc = '0; key_in = '0; pt_seed = '0; stall = 1'b0;
    tick(); tick();
    check("rst_aes_rst", 128'(bus.aes_rst), 128'(1));
    check("rst_trig", 128'(trig), 128'(0));
    check("rst_ct_valid", 128'(ct_valid), 128'(0));
    check("rst_done_all", 128'(done_all), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_timeout", 128'(timeout), 128'(0));
    check("rst_enc_cnt", 128'(enc_cnt), 128'(0));
    check("rst_ct_out", ct_out, 128'(0));
    check("rst_aes_din", bus.aes_din, 128'(0));
    check("rst_aes_key", bus.aes_key, 128'(0));
    rst = 1'b0;
    tick();

    // single encryption
    sb.push_back(CT1);
    c0 = nct;
    go(16'd1, 1'b0, P);
    check("load_busy", 128'(busy), 128'(1));
    check("load_aes_rst", 128'(bus.aes_rst), 128'(1));
    check("load_din", bus.aes_din, P);
    check("load_key", bus.aes_key, K);
    wait_done("single_done");
    check("single_nct", 128'(nct - c0), 128'(1));
    check("single_done_next", 128'(last_done), 128'(last_ct + 1));
    check("single_enc_cnt", 128'(enc_cnt), 128'(1));
    tick();
    check("single_idle_busy", 128'(busy), 128'(0));
    check("single_idle_rst", 128'(bus.aes_rst), 128'(1));

    // chained batch with a start pulse mid-batch
    ct2 = aes_enc(CT1, K);
    ct3 = aes_enc(ct2, K);
    sb.push_back(CT1); sb.push_back(ct2); sb.push_back(ct3);
    c0 = nct; t0 = ntrig; g0 = gaps.size();
    go(16'd3, 1'b1, P);
    repeat (8) tick();
    key_in = ~K; num_enc = 16'd7; chain = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_key", bus.aes_key, K);
    check("ignore_busy", 128'(busy), 128'(1));
    wait_done("chain_done");
    check("chain_nct", 128'(nct - c0), 128'(3));
    check("chain_ntrig", 128'(ntrig - t0), 128'(3));
    check("chain_ngaps", 128'(gaps.size() - g0), 128'(3));
    for (int i = g0 + 1; i < gaps.size(); i++)
      check("chain_trig_gap", 128'(gaps[i] >= GAP), 128'(1));
    check("chain_enc_cnt", 128'(enc_cnt), 128'(3));
    check("chain_sb_empty", 128'(sb.size()), 128'(0));
    tick();

    // counter mode wrapping all-ones to zero
    sb.push_back(aes_enc('1, K));
    sb.push_back(aes_enc('0, K));
    l0 = loads.size();
    go(16'd2, 1'b0, '1);
    wait_done("wrap_done");
    check("wrap_nloads", 128'(loads.size() - l0), 128'(2));
    check("wrap_first_din", loads[l0], '1);
    check("wrap_second_din", loads[l0 + 1], 128'(0));
    tick();

    // empty batch
    l0 = loads.size(); c0 = nct;
    go(16'd0, 1'b0, P);
    check("zero_done", 128'(done_all), 128'(1));
    tick();
    check("zero_done_once", 128'(done_all), 128'(0));
    check("zero_busy", 128'(busy), 128'(0));
    check("zero_no_load", 128'(loads.size() - l0), 128'(0));
    check("zero_no_ct", 128'(nct - c0), 128'(0));

    // core never finishes
    stall = 1'b1;
    r0 = nrun; d0 = ndone;
    go(16'd1, 1'b0, P);
    n = 0;
    while (timeout !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("tmo_seen", 128'(timeout), 128'(1));
    check("tmo_run_cycles", 128'(nrun - r0), 128'(TMO));
    check("tmo_err_aes_rst", 128'(bus.aes_rst), 128'(1));
    tick();
    check("tmo_busy", 128'(busy), 128'(0));
    check("tmo_no_done", 128'(ndone - d0), 128'(0));
    repeat (3) tick();
    check("tmo_sticky", 128'(timeout), 128'(1));
    stall = 1'b0;
    sb.push_back(CT1);
    go(16'd1, 1'b0, P);
    check("tmo_cleared", 128'(timeout), 128'(0));
    wait_done("tmo_recover_done");
    tick();

    // reset during RUN
    c0 = nct; d0 = ndone;
    go(16'd2, 1'b0, P);
    n = 0;
    while (trig !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("rr_in_run", 128'(trig), 128'(1));
    rst = 1'b1;
    #1;
    check("rr_trig", 128'(trig), 128'(0));
    check("rr_busy", 128'(busy), 128'(0));
    check("rr_aes_rst", 128'(bus.aes_rst), 128'(1));
    check("rr_enc_cnt", 128'(enc_cnt), 128'(0));
    check("rr_ct_out", ct_out, 128'(0));
    check("rr_aes_din", bus.aes_din, 128'(0));
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check("rr_no_ct", 128'(nct - c0), 128'(0));
    check("rr_no_done", 128'(ndone - d0), 128'(0));
    check("rr_stays_idle", 128'(busy), 128'(0));
    sb.push_back(CT1);
    go(16'd1, 1'b0, P);
    wait_done("rr_resume_done");
    check("rr_resume_nct", 128'(nct - c0), 128'(1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
